// File: rtl/spi_peripheral_if.sv
// Signal bundle between the SPI pins / protocol state machine and spi_peripheral.
// tx_underrun_cnt exists only when SPI_PERIPHERAL_UNDERRUN_EN is defined.
`timescale 1ns/1ps
interface spi_peripheral_if;
   logic       spi_sck;
   logic       spi_csn;
   logic       spi_sdi;
   logic       spi_sdo;
   logic [7:0] rx_data;
   logic       rx_stb;
   logic [7:0] tx_data;
   logic       tx_stb;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
   logic [7:0] tx_underrun_cnt;
`endif

   modport slave (
      input  spi_sck, spi_csn, spi_sdi, tx_data, tx_stb,
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      output tx_underrun_cnt,
`endif
      output spi_sdo, rx_data, rx_stb
   );

   modport master (
      output spi_sck, spi_csn, spi_sdi, tx_data, tx_stb,
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      input  tx_underrun_cnt,
`endif
      input  spi_sdo, rx_data, rx_stb
   );
endinterface

// File: rtl/spi_peripheral.sv
// Oversampled SPI mode-0 byte target (MSB first); SCK is sampled, never used as a clock.
// Optional saturating TX underrun counter enabled by SPI_PERIPHERAL_UNDERRUN_EN.
`timescale 1ns/1ps
module spi_peripheral (
   input  logic          clk,
   input  logic          rst_n,
   spi_peripheral_if.slave bus
);

   typedef enum logic {IDLE, SHIFT} state_e;

   logic [2:0] sck_sync_q;
   logic [2:0] csn_sync_q;
   logic [1:0] sdi_sync_q;
   logic       primed_q;
   logic       armed_q;

   state_e     state_q,    state_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_stb_q,   rx_stb_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] tx_hold_q,  tx_hold_d;
   logic       tx_valid_q, tx_valid_d;
   logic       reload_q,   reload_d;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
   logic [7:0] urun_cnt_q, urun_cnt_d;
`endif

   logic sck_rise, sck_fall, csn_fall, csn_rise, sdi_s, load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q <= '0;
         csn_sync_q <= '1;
         sdi_sync_q <= '0;
         primed_q   <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], bus.spi_sck};
         csn_sync_q <= {csn_sync_q[1:0], bus.spi_csn};
         sdi_sync_q <= {sdi_sync_q[0], bus.spi_sdi};
         primed_q   <= 1'b1;
         // Arm only after a genuinely sampled high CSn, so a CSn already low at reset release cannot start a frame
         armed_q    <= armed_q | (primed_q & csn_sync_q[0]);
      end
   end

   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2] & armed_q;
   assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
   assign sdi_s    = sdi_sync_q[1];

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_stb_d   = 1'b0;
      tx_shift_d = tx_shift_q;
      tx_hold_d  = tx_hold_q;
      tx_valid_d = tx_valid_q;
      reload_d   = reload_q;
      load       = 1'b0;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      urun_cnt_d = urun_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               reload_d  = 1'b0;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               reload_d  = 1'b0;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[5:0], sdi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d = {rx_shift_q, sdi_s};
                  rx_stb_d  = 1'b1;
                  reload_d  = 1'b1;
               end
            end else if (sck_fall) begin
               if (reload_q) begin
                  reload_d = 1'b0;
                  load     = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A tx_stb landing on the load cycle bypasses the holding register
      if (load) begin
         tx_valid_d = 1'b0;
         if (bus.tx_stb) begin
            tx_shift_d = bus.tx_data;
         end else if (tx_valid_q) begin
            tx_shift_d = tx_hold_q;
         end else begin
            tx_shift_d = '0;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
            if (urun_cnt_q != '1) urun_cnt_d = urun_cnt_q + 8'd1;
`endif
         end
      end else if (bus.tx_stb) begin
         tx_hold_d  = bus.tx_data;
         tx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_stb_q   <= 1'b0;
         tx_shift_q <= '0;
         tx_hold_q  <= '0;
         tx_valid_q <= 1'b0;
         reload_q   <= 1'b0;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
         urun_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_stb_q   <= rx_stb_d;
         tx_shift_q <= tx_shift_d;
         tx_hold_q  <= tx_hold_d;
         tx_valid_q <= tx_valid_d;
         reload_q   <= reload_d;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
         urun_cnt_q <= urun_cnt_d;
`endif
      end
   end

   assign bus.spi_sdo = (state_q == SHIFT) & tx_shift_q[7];
   assign bus.rx_data = rx_data_q;
   assign bus.rx_stb  = rx_stb_q;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
   assign bus.tx_underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed scoreboard bench for spi_peripheral: bit-banged SPI at clk/16 with
// expected received bytes queued at send time and matched against captured rx_stb bytes.
`timescale 1ns/1ps
module tb_spi_peripheral;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   spi_peripheral_if bus();
   spi_peripheral dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   logic [7:0] seen_mem [256];
   int         seen_wr = 0;
   int         seen_rd = 0;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.rx_stb === 1'b1) begin
         seen_mem[seen_wr[7:0]] <= bus.rx_data;
         seen_wr <= seen_wr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic tx_pulse(input logic [7:0] d);
      bus.tx_data = d;
      bus.tx_stb  = 1'b1;
      @(posedge clk);
      #2;
      bus.tx_stb  = 1'b0;
   endtask

   // Compare every queued expectation with captured bytes, then demand no extras
   task automatic drain(input string tag);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (seen_rd < seen_wr) begin
            chk({tag, "_rx_data"}, seen_mem[seen_rd[7:0]], e);
            seen_rd++;
         end else begin
            chk({tag, "_rx_missing"}, seen_wr - seen_rd, 1);
         end
      end
      chk({tag, "_rx_extra"}, seen_wr - seen_rd, 0);
      seen_rd = seen_wr;
   endtask

   task automatic spi_bits(input logic [7:0] mosi, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.spi_sdi = mosi[i];
         wait_clk(8);
         bus.spi_sck = 1'b1;
         wait_clk(8);
         bus.spi_sck = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] mosi, input bit last_fall, input bit resp,
                           input logic [7:0] resp_d, output logic [7:0] miso, output int lat);
      lat = 0;
      for (int i = 7; i >= 0; i--) begin
         bus.spi_sdi = mosi[i];
         wait_clk(8);
         miso[i] = bus.spi_sdo;
         bus.spi_sck = 1'b1;
         if (i == 0) begin
            int n;
            n = 0;
            for (int k = 1; k <= 6 && lat == 0; k++) begin
               @(posedge clk);
               #1;
               n = k;
               if (bus.rx_stb === 1'b1) lat = k;
            end
            if (resp && lat != 0) begin
               @(posedge clk); #1;
               bus.tx_data = resp_d;
               bus.tx_stb  = 1'b1;
               @(posedge clk); #1;
               bus.tx_stb  = 1'b0;
               n += 2;
            end
            repeat (8 - n) @(posedge clk);
            #2;
         end else begin
            wait_clk(8);
         end
         if (i != 0 || last_fall) bus.spi_sck = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] miso;
      int lat;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      int exp_cnt;
`endif
      bus.spi_sck = 1'b0;
      bus.spi_csn = 1'b1;
      bus.spi_sdi = 1'b0;
      bus.tx_stb  = 1'b0;
      bus.tx_data = '0;
      wait_clk(4);
      chk("reset_rx_data", bus.rx_data, 8'h00);
      chk("reset_rx_stb", bus.rx_stb, 1'b0);
      chk("reset_sdo", bus.spi_sdo, 1'b0);
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      chk("reset_underrun", bus.tx_underrun_cnt, 8'h00);
`endif
      rst_n = 1'b1;
      wait_clk(4);

      // Single byte, latency and empty first response
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'hA5);
      spi_byte(8'hA5, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("a5_latency", lat, 3);
      chk("a5_miso", miso, 8'h00);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("a5");

      // Multi-byte frame with responses to each rx_stb
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'h81);
      spi_byte(8'h81, 1'b1, 1'b1, 8'h5A, miso, lat);
      chk("frame_b0_latency", lat, 3);
      chk("frame_b0_miso", miso, 8'h00);
      exp_q.push_back(8'h3C);
      spi_byte(8'h3C, 1'b1, 1'b1, 8'hC3, miso, lat);
      chk("frame_b1_miso", miso, 8'h5A);
      exp_q.push_back(8'h00);
      spi_byte(8'h00, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("frame_b2_miso", miso, 8'hC3);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("frame");

      // Partial byte aborted by CSn, then a fresh frame
      bus.spi_csn = 1'b0;
      wait_clk(8);
      spi_bits(8'hFF, 5);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("partial");
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'h12);
      spi_byte(8'h12, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("after_partial_miso", miso, 8'h00);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("after_partial");

      // Last write wins in the holding register
      tx_pulse(8'h11);
      wait_clk(2);
      tx_pulse(8'h22);
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'h34);
      spi_byte(8'h34, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("overwrite_miso", miso, 8'h22);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);

      // tx_stb exactly on the CSn-fall load cycle is bypassed into the shifter
      bus.spi_csn = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      bus.tx_data = 8'h77;
      bus.tx_stb  = 1'b1;
      @(posedge clk); #1;
      bus.tx_stb  = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'h9E);
      spi_byte(8'h9E, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("bypass_miso", miso, 8'h77);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("holding");

      // Reset mid-byte with CSn held low
      tx_pulse(8'hFF);
      bus.spi_csn = 1'b0;
      wait_clk(8);
      chk("pre_reset_sdo", bus.spi_sdo, 1'b1);
      spi_bits(8'hF0, 4);
      bus.spi_sdi = 1'b1;
      wait_clk(4);
      bus.spi_sck = 1'b1;
      wait_clk(1);
      rst_n = 1'b0;
      wait_clk(2);
      chk("inreset_rx_data", bus.rx_data, 8'h00);
      chk("inreset_rx_stb", bus.rx_stb, 1'b0);
      chk("inreset_sdo", bus.spi_sdo, 1'b0);
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      chk("inreset_underrun", bus.tx_underrun_cnt, 8'h00);
`endif
      rst_n = 1'b1;
      wait_clk(4);
      bus.spi_sck = 1'b0;
      spi_byte(8'hFF, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("post_reset_no_stb", lat, 0);
      chk("post_reset_idle_miso", miso, 8'h00);
      wait_clk(8);
      drain("post_reset");
      bus.spi_csn = 1'b1;
      wait_clk(8);
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_q.push_back(8'h6B);
      spi_byte(8'h6B, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("rearm_latency", lat, 3);
      wait_clk(8);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("rearm");

`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      rst_n = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(4);
      exp_cnt = 0;
      bus.spi_csn = 1'b0;
      wait_clk(8);
      exp_cnt++;
      exp_q.push_back(8'h01);
      spi_byte(8'h01, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("urun_b0_miso", miso, 8'h00);
      exp_cnt++;
      exp_q.push_back(8'h02);
      spi_byte(8'h02, 1'b1, 1'b0, 8'h00, miso, lat);
      chk("urun_b1_miso", miso, 8'h00);
      exp_cnt++;
      exp_q.push_back(8'h03);
      spi_byte(8'h03, 1'b0, 1'b0, 8'h00, miso, lat);
      chk("urun_b2_miso", miso, 8'h00);
      chk("urun_three_bytes", bus.tx_underrun_cnt, exp_cnt);
      bus.spi_sck = 1'b0;
      wait_clk(8);
      exp_cnt++;
      chk("urun_final_reload", bus.tx_underrun_cnt, exp_cnt);
      bus.spi_csn = 1'b1;
      wait_clk(8);
      drain("urun");
      for (int i = 0; i < 300; i++) begin
         bus.spi_csn = 1'b0;
         wait_clk(4);
         bus.spi_csn = 1'b1;
         wait_clk(4);
         exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         if (i == 200) chk("urun_mid", bus.tx_underrun_cnt, exp_cnt);
      end
      chk("urun_saturated", bus.tx_underrun_cnt, exp_cnt);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
